fan_speed_ctrl: RTL and testbench
=================================

# fan_speed_ctrl

Sequential fan controller wrapped around the team's 4-bit temperature to 8-bit fan-pattern mapping. It samples temperature periodically and holds a speed level 0..3. Upward steps are soft-start ramped. Downward steps use hysteresis and a dwell time. An over-temperature alarm forces full speed. The 8-bit slot pattern of the active level is serialized onto a single fan drive line, frame by frame.

## Interface
- SAMPLE_DIV, 16: clock cycles per temperature sample tick (>=2)
- DWELL, 4: consecutive valid ticks required before each downward step (>=1)
- HYST, 1: temperature hysteresis subtracted from downward thresholds (0..2)
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- temp_i  in  4  temperature code 0..15
- temp_valid_i  in  1  temp_i valid; only sampled on a tick
- fan_o  out  1  serialized drive bit, pattern_o[slot]
- level_o  out  2  current speed level
- pattern_o  out  8  pattern of the frame currently being shifted
- alarm_o  out  1  over-temperature alarm

## Operation
- Reset values: level_o=0, pattern_o=0, fan_o=0, alarm_o=0. Internally, the divider, slot counter, dwell counter, alarm counter and temp_q are all 0.
- Tick: the divider counts 0..SAMPLE_DIV-1 and wraps. A tick occurs in the cycle where the divider equals SAMPLE_DIV-1.
- Sample: on a tick with temp_valid_i=1, temp_q<=temp_i, and every decision below uses temp_i from that tick. On a tick with temp_valid_i=0, all level, dwell and alarm state holds.
- Up thresholds: 3, 8 and 12. The raw target is 0 for T<3, 1 for T<8, 2 for T<12, and 3 otherwise.
- Down thresholds: level k>0 is retained while T >= thr_k - HYST.
- Up: if raw target > level, then level+1 on that tick, at most one step per tick, and the dwell counter clears.
- Down: if the hysteresis target < level, the dwell counter increments. When it reaches DWELL, level-1 and the counter clears. Any valid tick with target >= level clears the counter.
- Alarm set: alarm_o is set on the 2nd consecutive valid sample of T=15, and on that same edge level is forced to 3 and the dwell counter clears.
- While alarm_o=1: no down steps.
- Alarm clear: alarm_o clears on a valid sample with T<=11. Normal operation resumes from the next tick with the dwell counter at 0.
- Pattern LUT: 0→00000000, 1→00001111, 2→00110011, 3→11000011.
- Serializer: the slot counter 0..7 increments every cycle. fan_o = pattern_o[slot], LSB first. At the slot 7→0 wrap, pattern_o <= LUT(level_o).

## Timing
- level_o and alarm_o update on the clock edge ending the tick cycle.
- pattern_o updates only at frame boundaries.
- Worst-case latency from a level change to the new pattern on fan_o is 8 cycles.
- A tick coinciding with the frame wrap: the reload uses the pre-edge level, so the new level takes effect one frame later.
- fan_o is a decode of registers only, with no combinational path from any input.
- Reset mid-frame: on the next edge, all state returns to its reset value and fan_o=0.
- After reset release, the first tick is in cycle SAMPLE_DIV-1.

## Structure
- Shared package fan_pkg contains:
  - the 2-bit level typedef
  - threshold constants 3/8/12
  - alarm constants 15/11
  - the level→pattern LUT function
- Sub-module fan_serializer: slot counter, pattern register and fan_o decode, with inputs level and rst.
- The top level holds the divider, the level/dwell FSM and the alarm logic.
- FSM states:
  - STEADY: target == level.
  - RAMP_UP: target > level; transitions on each tick.
  - RAMP_DOWN: target < level; counts dwell.
  - ALARM: entered from any state on the alarm set condition. Exits to STEADY/RAMP_DOWN when the alarm clears.

## Test plan
All scenarios use SAMPLE_DIV=4, DWELL=3, HYST=1.
- Reset: hold rst 2 cycles with temp_i=0 valid, then run 32 cycles → all outputs 0 and fan_o constantly 0.
- Ramp up: temp_i=13 valid from reset → level_o 1/2/3 after ticks 1/2/3 (edges ending cycles 3/7/11). pattern_o reaches 11000011 at the following wrap, then fan_o over one frame = 1,1,0,0,0,0,1,1.
- Hysteresis (level 2, T=8):
  - T=7 for 5 ticks → level stays 2.
  - T=6 for 3 ticks → level 1 after the 3rd tick.
  - 6,6,9,6,6 → no step.
- Alarm (level 1):
  - One sample of 15, then 14 → alarm_o stays 0.
  - Two samples of 15 → alarm_o=1 and level_o=3 on the 2nd tick.
  - T=12 → alarm stays.
  - T=11 → alarm clears; level_o stays 3 (11 >= 12-1) until T drops to 10, then 2 after 3 further ticks.
- Valid gating: at level 2, set temp_i=0 with temp_valid_i=0 for 10 ticks → level_o and the dwell counter are frozen.
- Reset mid-frame: at level 3 and slot 4, assert rst → next edge shows level_o=0, pattern_o=0, fan_o=0 and slot 0.

Source files
------------

// File: rtl/fan_pkg.sv
// Shared types, thresholds and the level-to-pattern mapping for the fan controller.
package fan_pkg;

    typedef logic [1:0] level_t;

    typedef enum logic [1:0] {
        ST_STEADY,
        ST_RAMP_UP,
        ST_RAMP_DOWN,
        ST_ALARM
    } fan_state_t;

    localparam logic [3:0] THR_1       = 4'd3;
    localparam logic [3:0] THR_2       = 4'd8;
    localparam logic [3:0] THR_3       = 4'd12;
    localparam logic [3:0] ALARM_SET_T = 4'd15;
    localparam logic [3:0] ALARM_CLR_T = 4'd11;

    function automatic logic [7:0] pattern_lut(input level_t lvl);
        case (lvl)
            2'd1:    return 8'b0000_1111;
            2'd2:    return 8'b0011_0011;
            2'd3:    return 8'b1100_0011;
            default: return 8'b0000_0000;
        endcase
    endfunction

    function automatic level_t raw_target(input logic [3:0] t);
        if (t >= THR_3)      return 2'd3;
        else if (t >= THR_2) return 2'd2;
        else if (t >= THR_1) return 2'd1;
        else                 return 2'd0;
    endfunction

    // Highest level whose lowered threshold is still met; anything below the
    // current level means the level is no longer retained.
    function automatic level_t hyst_target(input logic [3:0] t, input logic [3:0] h);
        if (t >= THR_3 - h)      return 2'd3;
        else if (t >= THR_2 - h) return 2'd2;
        else if (t >= THR_1 - h) return 2'd1;
        else                     return 2'd0;
    endfunction

endpackage

// File: rtl/fan_serializer.sv
// Frame serializer: reloads the level pattern at each slot 7->0 wrap and drives it LSB first.
module fan_serializer
    import fan_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  level_t     level,
    output logic [7:0] pattern,
    output logic       fan
);

    logic [2:0] slot;

    always_ff @(posedge clk) begin
        if (rst) begin
            slot    <= 3'd0;
            pattern <= 8'd0;
        end else begin
            slot <= slot + 3'd1;
            if (slot == 3'd7)
                pattern <= pattern_lut(level);
        end
    end

    assign fan = pattern[slot];

endmodule

// File: rtl/fan_speed_ctrl.sv
// Fan controller: periodic temperature sampling, soft-start ramp, hysteresis/dwell
// ramp-down and an over-temperature alarm that pins the fan at full speed.
module fan_speed_ctrl
    import fan_pkg::*;
#(
    parameter int SAMPLE_DIV = 16,
    parameter int DWELL      = 4,
    parameter int HYST       = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] temp_i,
    input  logic       temp_valid_i,
    output logic       fan_o,
    output logic [1:0] level_o,
    output logic [7:0] pattern_o,
    output logic       alarm_o
);

    localparam int DIV_W = $clog2(SAMPLE_DIV);
    localparam int DW_W  = $clog2(DWELL + 1);

    logic [DIV_W-1:0] div;
    logic             tick;
    fan_state_t       state, state_n;
    level_t           level_q, level_n;
    logic [DW_W-1:0]  dwell_q, dwell_n;
    logic             alarm_cnt, acnt_n;
    logic [3:0]       temp_q, temp_n;
    logic             alarm_n;

    assign tick = (div == DIV_W'(SAMPLE_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            div       <= '0;
            state     <= ST_STEADY;
            level_q   <= 2'd0;
            dwell_q   <= '0;
            alarm_cnt <= 1'b0;
            temp_q    <= 4'd0;
        end else begin
            div       <= tick ? '0 : div + DIV_W'(1);
            state     <= state_n;
            level_q   <= level_n;
            dwell_q   <= dwell_n;
            alarm_cnt <= acnt_n;
            temp_q    <= temp_n;
        end
    end

    always_comb begin
        level_n = level_q;
        dwell_n = dwell_q;
        acnt_n  = alarm_cnt;
        temp_n  = temp_q;
        alarm_n = (state == ST_ALARM);
        if (tick && temp_valid_i) begin
            temp_n = temp_i;
            acnt_n = (temp_i == ALARM_SET_T);
            if (alarm_cnt && temp_i == ALARM_SET_T) begin
                alarm_n = 1'b1;
                level_n = 2'd3;
                dwell_n = '0;
            end else if (state == ST_ALARM) begin
                // Level is held through the clearing sample; normal stepping
                // restarts on the following tick.
                dwell_n = '0;
                if (temp_i <= ALARM_CLR_T)
                    alarm_n = 1'b0;
            end else if (raw_target(temp_i) > level_q) begin
                level_n = level_q + 2'd1;
                dwell_n = '0;
            end else if (hyst_target(temp_i, 4'(HYST)) < level_q) begin
                if (dwell_q == DW_W'(DWELL - 1)) begin
                    level_n = level_q - 2'd1;
                    dwell_n = '0;
                end else begin
                    dwell_n = dwell_q + DW_W'(1);
                end
            end else begin
                dwell_n = '0;
            end
        end

        if (alarm_n)
            state_n = ST_ALARM;
        else if (raw_target(temp_n) > level_n)
            state_n = ST_RAMP_UP;
        else if (hyst_target(temp_n, 4'(HYST)) < level_n)
            state_n = ST_RAMP_DOWN;
        else
            state_n = ST_STEADY;
    end

    always_comb begin
        level_o = level_q;
        alarm_o = (state == ST_ALARM);
    end

    fan_serializer u_ser (
        .clk     (clk),
        .rst     (rst),
        .level   (level_q),
        .pattern (pattern_o),
        .fan     (fan_o)
    );

endmodule

// File: tb/tb_fan_speed_ctrl.sv
// Directed bench for fan_speed_ctrl with SAMPLE_DIV=4, DWELL=3, HYST=1.
module tb_fan_speed_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] temp_i = 4'd0;
    logic       temp_valid_i = 1'b1;
    logic       fan_o;
    logic [1:0] level_o;
    logic [7:0] pattern_o;
    logic       alarm_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fan_speed_ctrl #(.SAMPLE_DIV(4), .DWELL(3), .HYST(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .temp_i       (temp_i),
        .temp_valid_i (temp_valid_i),
        .fan_o        (fan_o),
        .level_o      (level_o),
        .pattern_o    (pattern_o),
        .alarm_o      (alarm_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n, input logic [3:0] t, input logic v);
        temp_i       = t;
        temp_valid_i = v;
        cyc(4 * n);
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        temp_i       = 4'd0;
        temp_valid_i = 1'b1;
        cyc(2);
        rst = 1'b0;
    endtask

    initial begin
        int         fan_hi;
        logic [7:0] fb;

        // reset and idle
        cyc(2);
        chk("rst_level", level_o, 0);
        chk("rst_pattern", pattern_o, 0);
        chk("rst_fan", fan_o, 0);
        chk("rst_alarm", alarm_o, 0);
        rst    = 1'b0;
        fan_hi = 0;
        repeat (32) begin
            cyc(1);
            if (fan_o) fan_hi++;
        end
        chk("idle_fan_ones", fan_hi, 0);
        chk("idle_level", level_o, 0);
        chk("idle_pattern", pattern_o, 0);
        chk("idle_alarm", alarm_o, 0);

        // soft-start ramp
        do_reset();
        temp_i = 4'd13;
        cyc(3);
        chk("ramp_pre_first_tick", level_o, 0);
        cyc(1);
        chk("ramp_l1", level_o, 1);
        cyc(4);
        chk("ramp_l2", level_o, 2);
        chk("ramp_wrap_pre_edge", pattern_o, 8'h0F);
        cyc(4);
        chk("ramp_l3", level_o, 3);
        cyc(4);
        chk("ramp_pattern", pattern_o, 8'hC3);
        fb[0] = fan_o;
        for (int i = 1; i < 8; i++) begin
            cyc(1);
            fb[i] = fan_o;
        end
        chk("ramp_fan_frame", fb, 8'hC3);
        chk("ramp_alarm", alarm_o, 0);
        cyc(1);

        // hysteresis and dwell
        do_reset();
        ticks(2, 4'd8, 1'b1);
        chk("hyst_start_l2", level_o, 2);
        ticks(5, 4'd7, 1'b1);
        chk("hyst_t7_hold", level_o, 2);
        ticks(2, 4'd6, 1'b1);
        chk("hyst_t6_dwell2", level_o, 2);
        ticks(1, 4'd6, 1'b1);
        chk("hyst_t6_step", level_o, 1);
        ticks(1, 4'd8, 1'b1);
        chk("hyst_back_l2", level_o, 2);
        ticks(2, 4'd6, 1'b1);
        ticks(1, 4'd9, 1'b1);
        ticks(2, 4'd6, 1'b1);
        chk("hyst_interrupted", level_o, 2);
        ticks(1, 4'd6, 1'b1);
        chk("hyst_resume_step", level_o, 1);

        // valid gating freezes level and dwell
        ticks(1, 4'd8, 1'b1);
        chk("gate_l2", level_o, 2);
        ticks(2, 4'd6, 1'b1);
        ticks(10, 4'd0, 1'b0);
        chk("gate_level_frozen", level_o, 2);
        ticks(1, 4'd6, 1'b1);
        chk("gate_dwell_frozen", level_o, 1);

        // alarm
        do_reset();
        ticks(1, 4'd5, 1'b1);
        chk("alm_start_l1", level_o, 1);
        ticks(1, 4'd15, 1'b1);
        chk("alm_single15_alarm", alarm_o, 0);
        chk("alm_single15_level", level_o, 2);
        ticks(1, 4'd14, 1'b1);
        chk("alm_t14_alarm", alarm_o, 0);
        ticks(1, 4'd15, 1'b1);
        chk("alm_first15_again", alarm_o, 0);
        ticks(1, 4'd15, 1'b1);
        chk("alm_set", alarm_o, 1);
        chk("alm_set_level", level_o, 3);
        ticks(1, 4'd12, 1'b1);
        chk("alm_t12_hold", alarm_o, 1);
        ticks(1, 4'd3, 1'b0);
        chk("alm_invalid_hold", alarm_o, 1);
        chk("alm_invalid_level", level_o, 3);
        ticks(1, 4'd11, 1'b1);
        chk("alm_clear", alarm_o, 0);
        chk("alm_clear_level", level_o, 3);
        ticks(2, 4'd11, 1'b1);
        chk("alm_t11_retain", level_o, 3);
        ticks(2, 4'd10, 1'b1);
        chk("alm_t10_dwell", level_o, 3);
        ticks(1, 4'd10, 1'b1);
        chk("alm_t10_step", level_o, 2);

        // alarm forces full speed from level 1, across an invalid tick
        do_reset();
        ticks(1, 4'd15, 1'b1);
        chk("force_first_level", level_o, 1);
        chk("force_first_alarm", alarm_o, 0);
        ticks(1, 4'd0, 1'b0);
        chk("force_gap_level", level_o, 1);
        ticks(1, 4'd15, 1'b1);
        chk("force_alarm", alarm_o, 1);
        chk("force_level3", level_o, 3);

        // reset mid-frame
        do_reset();
        ticks(3, 4'd13, 1'b1);
        chk("midrst_pre_level", level_o, 3);
        chk("midrst_pre_slot", dut.u_ser.slot, 4);
        rst = 1'b1;
        cyc(1);
        chk("midrst_level", level_o, 0);
        chk("midrst_pattern", pattern_o, 0);
        chk("midrst_fan", fan_o, 0);
        chk("midrst_slot", dut.u_ser.slot, 0);
        chk("midrst_alarm", alarm_o, 0);
        rst = 1'b0;
        cyc(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
